grayscale_ctrl: RTL and testbench

GRAYSCALE_CTRL -- requirements
Module: grayscale_ctrl

---
 rtl/grayscale_pkg.sv | 26 ++
 rtl/grayscale_ctrl_if.sv | 40 ++++
 rtl/grayscale_credit.sv | 50 +++++
 rtl/grayscale_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_grayscale_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grayscale_pkg.sv
// Shared types and constants for the grayscale job controller: address type,
// controller states, DSM status-line field offsets and the FIFO depth default.
package grayscale_pkg;

  localparam int HC_ADDR_W = 42;
  typedef logic [HC_ADDR_W-1:0] t_hc_address;

  localparam int FIFO_DEPTH_DEFAULT = 64;

  localparam int DSM_W         = 512;
  localparam int DSM_FIELD_W   = 32;
  localparam int DSM_DONE_BIT  = 0;
  localparam int DSM_ERR_BIT   = 1;
  localparam int DSM_RSP_LSB   = 64;
  localparam int DSM_CYCLE_LSB = 128;
  localparam int DSM_STALL_LSB = 192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DSM,
    ST_DONE
  } t_ctrl_state;

endpackage

// File: rtl/grayscale_ctrl_if.sv
// Job control, read/write request and status signals of the grayscale controller.
// The slave modport is the controller side; master is the host/datapath side.
interface grayscale_ctrl_if #(
  parameter int CNT_W = 32
);
  import grayscale_pkg::*;

  logic                 start;
  t_hc_address          src_addr;
  t_hc_address          dst_addr;
  logic [CNT_W-1:0]     num_lines;
  t_hc_address          dsm_base;
  logic                 rd_req_valid;
  t_hc_address          rd_req_addr;
  logic                 rd_almfull;
  logic                 fifo_pop;
  logic                 wr_req_valid;
  t_hc_address          wr_req_addr;
  logic                 wr_is_dsm;
  logic                 wr_ready;
  logic                 wr_rsp_valid;
  logic                 busy;
  logic                 done;
  logic [DSM_W-1:0]     dsm_data;

  modport slave (
    input  start, src_addr, dst_addr, num_lines, dsm_base,
    input  rd_almfull, fifo_pop, wr_ready, wr_rsp_valid,
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_is_dsm,
    output busy, done, dsm_data
  );

  modport master (
    output start, src_addr, dst_addr, num_lines, dsm_base,
    output rd_almfull, fifo_pop, wr_ready, wr_rsp_valid,
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_is_dsm,
    input  busy, done, dsm_data
  );

endinterface

// File: rtl/grayscale_credit.sv
// Read-credit pool mirroring free space in the downstream pixel FIFO,
// with a sticky error for pops that would push the pool past its depth.
module grayscale_credit
  import grayscale_pkg::*;
#(
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int CRED_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic              pop,
  output logic [CRED_W-1:0] credits,
  output logic              err_ovf
);

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);

  logic [CRED_W-1:0] credits_q, credits_d;
  logic              err_ovf_q, err_ovf_d;
  logic              pop_ok;

  // A pop arriving with the pool already full is dropped and flagged.
  always_comb begin
    credits_d = credits_q;
    err_ovf_d = err_ovf_q;
    pop_ok    = pop && (credits_q != CRED_FULL);
    if (pop && !pop_ok) err_ovf_d = 1'b1;
    case ({issue, pop_ok})
      2'b10:   credits_d = credits_q - CRED_ONE;
      2'b01:   credits_d = credits_q + CRED_ONE;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CRED_FULL;
      err_ovf_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign credits = credits_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: rtl/grayscale_ctrl.sv
// Grayscale job controller: sequences source reads under FIFO credits, destination
// writes, and a final DSM status write. Define GRAYSCALE_CTRL_PERF_EN for perf counters.
module grayscale_ctrl
  import grayscale_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              reset_n,
  grayscale_ctrl_if.slave  bus
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  t_ctrl_state       state_q, state_d;
  t_hc_address       src_q, src_d, dst_q, dst_d, base_q, base_d;
  logic [CNT_W-1:0]  lines_q, lines_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic              dsm_sent_q, dsm_sent_d;
  logic              rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d, wr_dsm_q, wr_dsm_d;
  t_hc_address       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DSM_W-1:0]  dsm_data_q, dsm_data_d;
  logic              rd_go, wr_go;
  logic [CRED_W-1:0] credits;
  logic              err_ovf;

  grayscale_credit #(.FIFO_DEPTH(FIFO_DEPTH)) u_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .issue   (rd_go),
    .pop     (bus.fifo_pop),
    .credits (credits),
    .err_ovf (err_ovf)
  );

`ifdef GRAYSCALE_CTRL_PERF_EN
  logic [DSM_FIELD_W-1:0] cycle_q, cycle_d, stall_q, stall_d;
  logic                   perf_clr;

  assign perf_clr = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;

  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (perf_clr) begin
      cycle_d = '0;
      stall_d = '0;
    end else begin
      if (state_q inside {ST_RUN, ST_FLUSH, ST_DSM}) cycle_d = cycle_q + DSM_FIELD_W'(1);
      if ((state_q == ST_RUN) && (rd_cnt_q < lines_q) && ((credits == '0) || bus.rd_almfull))
        stall_d = stall_q + DSM_FIELD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end
`endif

  // Request decisions are registered, so counters advance on the same edge the valid rises.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    base_d     = base_q;
    lines_d    = lines_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    dsm_sent_d = dsm_sent_q;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_dsm_d   = 1'b0;

    rd_go = (state_q == ST_RUN) && (rd_cnt_q < lines_q) && (credits != '0) && !bus.rd_almfull;
    wr_go = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && bus.wr_ready && (wr_cnt_q < lines_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          src_d      = bus.src_addr;
          dst_d      = bus.dst_addr;
          base_d     = bus.dsm_base;
          lines_d    = bus.num_lines;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          rsp_cnt_d  = '0;
          dsm_sent_d = 1'b0;
        end
      end
      ST_RUN:   if (rd_cnt_q == lines_q) state_d = ST_FLUSH;
      ST_FLUSH: if (rsp_cnt_q == lines_q) state_d = ST_DSM;
      ST_DSM: begin
        if (!dsm_sent_q && bus.wr_ready) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = base_q;
          wr_dsm_d   = 1'b1;
          dsm_sent_d = 1'b1;
        end else if (dsm_sent_q && bus.wr_rsp_valid) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_go) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = src_q + t_hc_address'(rd_cnt_q);
      rd_cnt_d   = rd_cnt_q + CNT_ONE;
    end
    if (wr_go) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = dst_q + t_hc_address'(wr_cnt_q);
      wr_cnt_d   = wr_cnt_q + CNT_ONE;
    end
    if (bus.wr_rsp_valid && ((state_q == ST_RUN) || (state_q == ST_FLUSH)))
      rsp_cnt_d = rsp_cnt_q + CNT_ONE;

    busy_d = state_d inside {ST_RUN, ST_FLUSH, ST_DSM};
    done_d = (state_d == ST_DONE);

    dsm_data_d                                 = '0;
    dsm_data_d[DSM_DONE_BIT]                   = 1'b1;
    dsm_data_d[DSM_ERR_BIT]                    = err_ovf;
    dsm_data_d[DSM_RSP_LSB +: DSM_FIELD_W]     = DSM_FIELD_W'(rsp_cnt_q);
`ifdef GRAYSCALE_CTRL_PERF_EN
    dsm_data_d[DSM_CYCLE_LSB +: DSM_FIELD_W]   = cycle_q;
    dsm_data_d[DSM_STALL_LSB +: DSM_FIELD_W]   = stall_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      base_q     <= '0;
      lines_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rsp_cnt_q  <= '0;
      dsm_sent_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_dsm_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dsm_data_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      base_q     <= base_d;
      lines_q    <= lines_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      dsm_sent_q <= dsm_sent_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_dsm_q   <= wr_dsm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dsm_data_q <= dsm_data_d;
    end
  end

  assign bus.rd_req_valid = rd_valid_q;
  assign bus.rd_req_addr  = rd_addr_q;
  assign bus.wr_req_valid = wr_valid_q;
  assign bus.wr_req_addr  = wr_addr_q;
  assign bus.wr_is_dsm    = wr_dsm_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.dsm_data     = dsm_data_q;

endmodule

// File: tb/tb_grayscale_ctrl.sv
// Bench for grayscale_ctrl: transaction-level scoreboard of reads, writes, credits
// and DSM status, plus directed jobs with hand-computed expectations.
module tb_grayscale_ctrl;
  import grayscale_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  grayscale_ctrl_if #(.CNT_W(CW)) bus ();

  grayscale_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Job description as seen by the model, plus observed transaction counts.
  t_hc_address job_src, job_dst, job_base, exp_addr, first_rd, last_rd;
  int          job_lines, rd_seen, wr_seen, dsm_seen, done_events;
  int          m_credits;
  bit          m_err, prev_done, full_now;
  logic        cap_pop, cap_almfull, cap_ready, cap_rstn;

  bit auto_pop, rsp_en;
  int manual_pops, pop_owed, rsp_owed;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input t_hc_address src, input t_hc_address dst,
                               input t_hc_address base, input int lines);
    @(negedge clk);
    bus.src_addr  = src;
    bus.dst_addr  = dst;
    bus.dsm_base  = base;
    bus.num_lines = CW'(lines);
    job_src = src; job_dst = dst; job_base = base; job_lines = lines;
    rd_seen = 0; wr_seen = 0; dsm_seen = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_budget", bus.done, 1);
  endtask

  // Inputs as the DUT sampled them at each rising edge.
  initial forever begin
    @(posedge clk);
    cap_pop     = bus.fifo_pop;
    cap_almfull = bus.rd_almfull;
    cap_ready   = bus.wr_ready;
    cap_rstn    = reset_n;
  end

  // Scoreboard: every visible request is judged against the credit pool and job plan.
  initial forever begin
    @(negedge clk);
    if (cap_rstn !== 1'b1) begin
      m_credits = DEPTH; m_err = 0; prev_done = 0;
      rd_seen = 0; wr_seen = 0; dsm_seen = 0;
    end else begin
      if (bus.rd_req_valid) begin
        exp_addr = job_src + t_hc_address'(rd_seen);
        checkOutput("rd_credit_avail", m_credits > 0, 1);
        checkOutput("rd_almfull_gate", cap_almfull, 0);
        checkOutput("rd_within_job", rd_seen < job_lines, 1);
        checkOutput("rd_addr", bus.rd_req_addr, exp_addr);
        if (rd_seen == 0) first_rd = bus.rd_req_addr;
        last_rd = bus.rd_req_addr;
        rd_seen++;
      end
      full_now = (m_credits == DEPTH);
      if (cap_pop && full_now) m_err = 1;
      m_credits = m_credits - int'(bus.rd_req_valid) + int'(cap_pop && !full_now);
      if (bus.wr_req_valid) begin
        checkOutput("wr_ready_gate", cap_ready, 1);
        if (bus.wr_is_dsm) begin
          checkOutput("dsm_addr", bus.wr_req_addr, job_base);
          checkOutput("dsm_after_data", wr_seen, job_lines);
          checkOutput("dsm_once", dsm_seen, 0);
          dsm_seen++;
        end else begin
          exp_addr = job_dst + t_hc_address'(wr_seen);
          checkOutput("wr_within_job", wr_seen < job_lines, 1);
          checkOutput("wr_addr", bus.wr_req_addr, exp_addr);
          wr_seen++;
        end
      end
      checkOutput("busy_done_excl", bus.busy && bus.done, 0);
      if (bus.done && !prev_done) begin
        done_events++;
        checkOutput("done_reads", rd_seen, job_lines);
        checkOutput("done_writes", wr_seen, job_lines);
        checkOutput("done_dsm_writes", dsm_seen, 1);
        checkOutput("dsm_bit0", bus.dsm_data[0], 1);
        checkOutput("dsm_err_bit", bus.dsm_data[1], m_err);
        checkOutput("dsm_rsp_cnt", bus.dsm_data[95:64], job_lines);
`ifndef GRAYSCALE_CTRL_PERF_EN
        checkOutput("dsm_perf_fields_zero", |{bus.dsm_data[159:128], bus.dsm_data[223:192]}, 0);
`else
        checkOutput("dsm_cycle_nonzero", bus.dsm_data[159:128] != 0, 1);
`endif
      end
      prev_done = bus.done;
    end
  end

  // FIFO drain model: each read owes one pop, released manually or automatically.
  initial begin
    bus.fifo_pop = 1'b0;
    pop_owed = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pop_owed = 0;
        bus.fifo_pop = 1'b0;
      end else begin
        if (bus.rd_req_valid) pop_owed++;
        bus.fifo_pop = 1'b0;
        if (manual_pops > 0) begin
          bus.fifo_pop = 1'b1;
          manual_pops--;
          if (pop_owed > 0) pop_owed--;
        end else if (auto_pop && pop_owed > 0) begin
          bus.fifo_pop = 1'b1;
          pop_owed--;
        end
      end
    end
  end

  // Write responder: one response per write request, one cycle later.
  initial begin
    bus.wr_rsp_valid = 1'b0;
    rsp_owed = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rsp_owed = 0;
        bus.wr_rsp_valid = 1'b0;
      end else begin
        if (bus.wr_req_valid) rsp_owed++;
        bus.wr_rsp_valid = 1'b0;
        if (rsp_en && rsp_owed > 0) begin
          bus.wr_rsp_valid = 1'b1;
          rsp_owed--;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.dsm_base = '0;
    bus.num_lines = '0; bus.rd_almfull = 1'b0; bus.wr_ready = 1'b0;
    auto_pop = 1; rsp_en = 1; manual_pops = 0; done_events = 0;
    job_lines = 0; job_src = '0; job_dst = '0; job_base = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_rd_valid", bus.rd_req_valid, 0);
    checkOutput("rst_wr_valid", bus.wr_req_valid, 0);
    checkOutput("rst_dsm_data", |bus.dsm_data, 0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    bus.wr_ready = 1'b1;

    // Eight lines, no backpressure.
    applyStimulus(42'h100, 42'h800, 42'h40, 8);
    wait_done(200);
    checkOutput("t1_reads", rd_seen, 8);
    checkOutput("t1_writes", wr_seen, 8);
    checkOutput("t1_first_rd", first_rd, 42'h100);
    checkOutput("t1_last_rd", last_rd, 42'h107);
    checkOutput("t1_dsm_lines", bus.dsm_data[95:64], 8);
    checkOutput("t1_dsm_err", bus.dsm_data[1], 0);

    // Empty job goes straight to the status write.
    applyStimulus(42'h200, 42'h900, 42'h41, 0);
    wait_done(50);
    checkOutput("t2_reads", rd_seen, 0);
    checkOutput("t2_writes", wr_seen, 0);
    checkOutput("t2_dsm", dsm_seen, 1);

    // Extra pop at full credits, then credit starvation with manual pops.
    auto_pop = 0;
    @(negedge clk);
    manual_pops = 1;
    repeat (3) @(negedge clk);
    applyStimulus(42'h1000, 42'h2000, 42'h42, 16);
    repeat (30) @(negedge clk);
    checkOutput("t3_stall_reads", rd_seen, 4);
    manual_pops = 1;
    repeat (10) @(negedge clk);
    checkOutput("t3_one_pop_one_read", rd_seen, 5);
    manual_pops = 2;
    repeat (10) @(negedge clk);
    checkOutput("t3_issue_and_pop", rd_seen, 7);
    auto_pop = 1;
    wait_done(300);
    checkOutput("t3_ovf_dsm_bit", bus.dsm_data[1], 1);
    checkOutput("t3_reads", rd_seen, 16);

    // Almost-full and wr_ready low hold off all requests.
    bus.rd_almfull = 1'b1;
    bus.wr_ready = 1'b0;
    applyStimulus(42'h1800, 42'h2800, 42'h45, 5);
    repeat (10) @(negedge clk);
    checkOutput("t4_almfull_reads", rd_seen, 0);
    checkOutput("t4_notready_writes", wr_seen, 0);
    bus.rd_almfull = 1'b0;
    bus.wr_ready = 1'b1;
    wait_done(100);

    // Reset while stuck in FLUSH waiting for write responses.
    rsp_en = 0;
    applyStimulus(42'h3000, 42'h4000, 42'h43, 4);
    repeat (20) @(negedge clk);
    checkOutput("t5_reads", rd_seen, 4);
    checkOutput("t5_writes", wr_seen, 4);
    checkOutput("t5_busy_in_flush", bus.busy, 1);
    #2 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_busy", bus.busy, 0);
    checkOutput("t5_rst_done", bus.done, 0);
    checkOutput("t5_rst_rd_valid", bus.rd_req_valid, 0);
    checkOutput("t5_rst_wr_valid", bus.wr_req_valid, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    rsp_en = 1;
    applyStimulus(42'h5000, 42'h6000, 42'h44, 3);
    wait_done(100);
    checkOutput("t5_new_reads", rd_seen, 3);
    checkOutput("t5_err_cleared", bus.dsm_data[1], 0);

    repeat (2) @(negedge clk);
    checkOutput("done_events", done_events, 5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
